// File: rtl/ff_regfile_mp.sv
// Flip-flop register file: one byte-enabled write port, NRD read ports,
// per-entry valid bits, bulk clear, occupancy count and error reporting.
module ff_regfile_mp #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 4,
    parameter  int DATA_N = 12,
    parameter  int NRD    = 2,
    localparam int BE_W   = DATA_W / 8,
    localparam int CNT_W  = $clog2(DATA_N + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [BE_W-1:0]       wr_be_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  clr_i,
    input  logic [NRD-1:0]        rd_en_i,
    input  logic [NRD*ADDR_W-1:0] rd_addr_i,
    output logic [NRD-1:0]        rd_vld_o,
    output logic [NRD*DATA_W-1:0] rd_data_o,
    output logic [NRD-1:0]        rd_err_o,
    output logic                  wr_err_o,
    output logic [CNT_W-1:0]      vld_cnt_o
);

    // One extra bit so DATA_N == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DATA_N);

    logic [DATA_W-1:0]     mem_q [DATA_N];
    logic [DATA_N-1:0]     vld_q;
    logic [DATA_N-1:0]     vld_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  wr_ok;
    logic [DATA_W-1:0]     old_w;
    logic [DATA_W-1:0]     merged;
    logic                  wr_err_q;
    logic                  wr_err_d;
    logic [NRD-1:0]        rd_vld_q;
    logic [NRD-1:0]        rd_vld_d;
    logic [NRD-1:0]        rd_err_q;
    logic [NRD-1:0]        rd_err_d;
    logic [NRD*DATA_W-1:0] rd_data_q;
    logic [NRD*DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0]     rdat [NRD];
    logic [NRD-1:0]        hit;

    // Write acceptance, byte merge and next valid/count state.
    always_comb begin
        wr_ok    = wr_i && ({1'b0, wr_addr_i} < LIMIT) && (wr_be_i != '0);
        wr_err_d = wr_i && !wr_ok;
        old_w    = '0;
        for (int i = 0; i < DATA_N; i++) begin
            if (wr_addr_i == ADDR_W'(i) && vld_q[i] && !clr_i) begin
                old_w = mem_q[i];
            end
        end
        merged = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (wr_be_i[b]) begin
                merged[8*b +: 8] = wr_data_i[8*b +: 8];
            end
        end
        vld_d = clr_i ? '0 : vld_q;
        for (int i = 0; i < DATA_N; i++) begin
            if (wr_ok && wr_addr_i == ADDR_W'(i)) begin
                vld_d[i] = 1'b1;
            end
        end
        cnt_d = '0;
        for (int i = 0; i < DATA_N; i++) begin
            cnt_d = cnt_d + CNT_W'(vld_d[i]);
        end
    end

    // Per-port read lookup with write-first bypass on the pre-edge state.
    always_comb begin
        rd_vld_d  = rd_en_i;
        rd_err_d  = '0;
        rd_data_d = '0;
        for (int p = 0; p < NRD; p++) begin
            rdat[p] = '0;
            hit[p]  = 1'b0;
            for (int i = 0; i < DATA_N; i++) begin
                if (rd_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(i) && vld_q[i]) begin
                    rdat[p] = mem_q[i];
                    hit[p]  = 1'b1;
                end
            end
            if (wr_ok && rd_addr_i[p*ADDR_W +: ADDR_W] == wr_addr_i) begin
                rdat[p] = merged;
                hit[p]  = 1'b1;
            end
            if (rd_en_i[p]) begin
                rd_data_d[p*DATA_W +: DATA_W] = hit[p] ? rdat[p] : '0;
                rd_err_d[p]                   = !hit[p];
            end
        end
    end

    // Entry storage; not reset, and writes during reset are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_N; i++) begin
            if (resetn && wr_ok && wr_addr_i == ADDR_W'(i)) begin
                mem_q[i] <= merged;
            end
        end
    end

    // Control state and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q     <= '0;
            cnt_q     <= '0;
            wr_err_q  <= 1'b0;
            rd_vld_q  <= '0;
            rd_err_q  <= '0;
            rd_data_q <= '0;
        end else begin
            vld_q     <= vld_d;
            cnt_q     <= cnt_d;
            wr_err_q  <= wr_err_d;
            rd_vld_q  <= rd_vld_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_vld_o  = rd_vld_q;
    assign rd_data_o = rd_data_q;
    assign rd_err_o  = rd_err_q;
    assign wr_err_o  = wr_err_q;
    assign vld_cnt_o = cnt_q;

endmodule

// File: tb/tb_ff_regfile_mp.sv
// Testbench for ff_regfile_mp: directed vector table, hand sequences
// and randomized traffic against an array-based reference model.
module tb_ff_regfile_mp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr;
    logic [3:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        clr;
    logic [1:0]  re;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [1:0]  rd_vld;
    logic [63:0] rd_data;
    logic [1:0]  rd_err;
    logic        wr_err;
    logic [3:0]  vld_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_mem [16];
    bit          m_vld [16];

    always #5 clk = ~clk;

    ff_regfile_mp dut (
        .clk       (clk),
        .resetn    (resetn),
        .wr_i      (wr),
        .wr_addr_i (wa),
        .wr_be_i   (be),
        .wr_data_i (wd),
        .clr_i     (clr),
        .rd_en_i   (re),
        .rd_addr_i ({ra1, ra0}),
        .rd_vld_o  (rd_vld),
        .rd_data_o (rd_data),
        .rd_err_o  (rd_err),
        .wr_err_o  (wr_err),
        .vld_cnt_o (vld_cnt)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        clr;
        logic [1:0]  re;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [1:0]  xvld;
        logic [31:0] xd0;
        logic [31:0] xd1;
        logic [1:0]  xerr;
        logic        xwerr;
        logic [3:0]  xcnt;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        wr = 0; wa = 0; be = 0; wd = 0; clr = 0; re = 0; ra0 = 0; ra1 = 0;
    endtask

    // One clock: model predicts, edge, then compare DUT with the model.
    task automatic tick();
        logic [1:0]  ev;
        logic [1:0]  ee;
        logic [31:0] ed [2];
        logic        ew;
        logic [31:0] nv;
        logic [3:0]  ra [2];
        bit          wok;
        int          cnt;
        ra[0] = ra0;
        ra[1] = ra1;
        ev = 0; ee = 0; ed[0] = 0; ed[1] = 0; ew = 0;
        if (!resetn) begin
            for (int i = 0; i < 16; i++) m_vld[i] = 0;
        end else begin
            wok = wr && (wa < 12) && (be != 0);
            ew  = wr && !wok;
            nv  = (m_vld[wa] && !clr) ? m_mem[wa] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (be[b]) nv[8*b +: 8] = wd[8*b +: 8];
            for (int p = 0; p < 2; p++) begin
                if (re[p]) begin
                    ev[p] = 1;
                    if (wok && ra[p] == wa) ed[p] = nv;
                    else if (ra[p] < 12 && m_vld[ra[p]]) ed[p] = m_mem[ra[p]];
                    else ee[p] = 1;
                end
            end
            if (clr) for (int i = 0; i < 16; i++) m_vld[i] = 0;
            if (wok) begin
                m_mem[wa] = nv;
                m_vld[wa] = 1;
            end
        end
        cnt = 0;
        for (int i = 0; i < 16; i++) cnt += int'(m_vld[i]);
        @(posedge clk);
        #1;
        chk("m_rd_vld", 64'(rd_vld), 64'(ev));
        chk("m_rd_err", 64'(rd_err), 64'(ee));
        chk("m_rd_data0", 64'(rd_data[31:0]), 64'(ed[0]));
        chk("m_rd_data1", 64'(rd_data[63:32]), 64'(ed[1]));
        chk("m_wr_err", 64'(wr_err), 64'(ew));
        chk("m_vld_cnt", 64'(vld_cnt), 64'(cnt));
    endtask

    initial begin
        vt[0] = '{0, 0, 0, 0, 0, 2'b01, 3, 0,
                  2'b01, 0, 0, 2'b01, 0, 0};
        vt[1] = '{1, 5, 4'hF, 32'hA1B2C3D4, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 1};
        vt[2] = '{1, 5, 4'h1, 32'hFFFFFFFF, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 1};
        vt[3] = '{0, 0, 0, 0, 0, 2'b10, 0, 5,
                  2'b10, 0, 32'hA1B2C3FF, 0, 0, 1};
        vt[4] = '{1, 2, 4'h3, 32'h12345678, 0, 2'b11, 2, 2,
                  2'b11, 32'h00005678, 32'h00005678, 0, 0, 2};
        vt[5] = '{1, 13, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0,
                  0, 0, 0, 0, 1, 2};
        vt[6] = '{1, 1, 4'h0, 32'hCAFEF00D, 0, 2'b01, 13, 0,
                  2'b01, 0, 0, 2'b01, 1, 2};
        vt[7] = '{0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 2};

        idle();
        resetn = 0;
        tick();
        tick();
        resetn = 1;

        for (int k = 0; k < 8; k++) begin
            wr = vt[k].wr; wa = vt[k].wa; be = vt[k].be; wd = vt[k].wd;
            clr = vt[k].clr; re = vt[k].re; ra0 = vt[k].ra0; ra1 = vt[k].ra1;
            tick();
            chk($sformatf("v%0d_vld", k), 64'(rd_vld), 64'(vt[k].xvld));
            chk($sformatf("v%0d_d0", k), 64'(rd_data[31:0]), 64'(vt[k].xd0));
            chk($sformatf("v%0d_d1", k), 64'(rd_data[63:32]), 64'(vt[k].xd1));
            chk($sformatf("v%0d_err", k), 64'(rd_err), 64'(vt[k].xerr));
            chk($sformatf("v%0d_werr", k), 64'(wr_err), 64'(vt[k].xwerr));
            chk($sformatf("v%0d_cnt", k), 64'(vld_cnt), 64'(vt[k].xcnt));
        end

        // Fill every entry, then clear together with a write.
        idle();
        for (int i = 0; i < 12; i++) begin
            wr = 1; wa = 4'(i); be = 4'hF; wd = 32'h01010101 * i;
            tick();
        end
        idle();
        tick();
        chk("fill_cnt", 64'(vld_cnt), 64'd12);
        clr = 1; wr = 1; wa = 7; be = 4'hF; wd = 32'h77;
        tick();
        chk("clr_cnt", 64'(vld_cnt), 64'd1);
        idle();
        re = 2'b11; ra0 = 7; ra1 = 0;
        tick();
        chk("clr_rd7", 64'(rd_data[31:0]), 64'h77);
        chk("clr_err", 64'(rd_err), 64'b10);

        // Reads pending when reset arrives are dropped; reset-cycle write too.
        re = 2'b11; ra0 = 7; ra1 = 7;
        tick();
        resetn = 0; wr = 1; wa = 3; be = 4'hF; wd = 32'h33;
        tick();
        chk("rst_vld", 64'(rd_vld), 64'd0);
        resetn = 1;
        idle();
        tick();
        chk("rst_noresp", 64'(rd_vld), 64'd0);
        chk("rst_cnt", 64'(vld_cnt), 64'd0);
        for (int i = 0; i < 12; i += 2) begin
            re = 2'b11; ra0 = 4'(i); ra1 = 4'(i + 1);
            tick();
            chk("rst_inval", 64'(rd_err), 64'b11);
        end

        // Randomized traffic; clr only in cycles without a write.
        for (int n = 0; n < 600; n++) begin
            resetn = ($urandom_range(0, 49) != 0);
            wr  = $urandom_range(0, 1);
            wa  = 4'($urandom_range(0, 15));
            be  = 4'($urandom);
            wd  = $urandom;
            clr = !wr && ($urandom_range(0, 19) == 0);
            re  = 2'($urandom);
            ra0 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ff_regfile_mp.md
Name: ff_regfile_mp

Overview:
Parametrised flip-flop register file with one byte-enabled write port and NRD independent read ports. Each entry carries a valid bit. Adds bulk invalidate, an occupancy count, registered read outputs with write-first bypass, and per-port error reporting. Used as a small scoreboard or config store next to pipeline control logic where SRAM is not justified.

Parameters:
DATA_W, 32, entry width in bits; must be a multiple of 8
ADDR_W, 4, address width
DATA_N, 12, number of entries; 1 <= DATA_N <= 2**ADDR_W
NRD, 2, number of read ports, 1..4
BE_W, DATA_W/8, derived byte-enable width; not overridable
CNT_W, $clog2(DATA_N+1), derived occupancy-count width

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
wr  in  1  write request
wr_addr  in  ADDR_W  write address
wr_be  in  BE_W  byte enables; bit b covers data bits [8b+7:8b]
wr_data  in  DATA_W  write data
clr  in  1  invalidate all entries
rd_en  in  NRD  per-port read request
rd_addr  in  NRD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W]
rd_vld  out  NRD  read response valid, one cycle after rd_en
rd_data  out  NRD*DATA_W  read data; port p occupies bits [p*DATA_W +: DATA_W]
rd_err  out  NRD  response is for an invalid or out-of-range entry
wr_err  out  1  registered pulse: previous-cycle write was out of range or had wr_be == 0
vld_cnt  out  CNT_W  number of valid entries

Behaviour:
- Reset (resetn = 0 at posedge):
  - All valid bits, rd_vld, rd_data, rd_err, wr_err and vld_cnt are 0.
  - Entry storage is not reset.
- Write acceptance:
  - A write is accepted when wr = 1, wr_addr < DATA_N and wr_be != 0.
  - At the clock edge, enabled bytes take wr_data.
  - Disabled bytes keep their old value if the entry was valid, and become 0 if it was invalid.
  - The entry's valid bit becomes 1.
- Write rejection:
  - wr = 1 with wr_addr >= DATA_N, or with wr_be == 0: no state change, and wr_err = 1 on the next cycle.
  - wr_err is 0 in every other cycle.
- Clear:
  - clr = 1 clears all valid bits at the edge.
  - If an accepted write happens in the same cycle, that entry ends up valid and holds the merged data, with old bytes treated as zero.
  - The only valid entry afterwards is the written one, so vld_cnt = 1.
- Reads (per port p):
  - rd_en[p] = 1 in cycle T gives rd_vld[p] = 1 in cycle T+1 with registered rd_data and rd_err. Latency is exactly 1 and there is no backpressure.
  - Read data is computed from the cycle-T pre-edge state, with one exception: if an accepted write targets the same address in cycle T, the read returns the post-write merged value with rd_err = 0 (write-first bypass).
  - clr in cycle T does not affect reads issued in cycle T.
  - If the address is >= DATA_N, or the entry is invalid and not bypassed, then rd_data = 0 and rd_err = 1.
  - When rd_vld[p] = 0, rd_data[p] = 0 and rd_err[p] = 0.
- Multi-port:
  - All ports are independent.
  - Any number of ports may read the same address in the same cycle, including the address being written.
  - Read and write in the same cycle is legal and is not an error.
- vld_cnt:
  - Registered and always equal to the popcount of the valid bits.
  - Updates on the same edge as the valid bits.
  - Saturation cannot occur, since CNT_W covers DATA_N.
- Reset asserted mid-operation:
  - Reads issued in the reset cycle produce no response.
  - Any pending response is dropped.
  - A write in the reset cycle is discarded, and its entry stays invalid.

Test Plan:
1. Reset, then read port 0 addr 3 -> next cycle rd_vld[0]=1, rd_err[0]=1, rd_data=0, vld_cnt=0.
2. Write addr 5 data 0xA1B2C3D4 be=4'b1111; next cycle write addr 5 data 0xFFFFFFFF be=4'b0001; then read port 1 addr 5 -> rd_data=0xA1B2C3FF, rd_err=0, vld_cnt=1.
3. Write-first bypass: same cycle write addr 2 data 0x12345678 be=4'b0011 (entry invalid), port 0 and port 1 both read addr 2 -> both rd_data=0x00005678, rd_err=0.
4. Fill entries 0..11, then clr together with write addr 7 data 0x77 be=4'b1111 -> vld_cnt goes 12 then 1; read addr 7 returns 0x77; read addr 0 gives rd_err=1.
5. Write wr_addr=13 (DATA_N=12), then write addr 1 with be=0 -> wr_err pulses on each following cycle, vld_cnt unchanged; read addr 13 gives rd_err=1, rd_data=0.
6. Issue rd_en on both ports, then assert resetn=0 the next cycle -> rd_vld stays 0 after the reset edge, and all entries are invalid afterwards.
